// File: rtl/io_pkg.sv
// Shared definitions for the io_channels block.
// Holds the channel select register width, the status word layout and
// a helper that assembles a status word from per-channel flags.
package io_pkg;

    localparam int unsigned SEL_W  = 8;
    localparam int unsigned STAT_W = 8;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_OVF      = 4;
    localparam int unsigned ST_UNF      = 5;

    // Build the status word; unused upper bits stay zero.
    function automatic logic [STAT_W-1:0] pack_status(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_full,
        input logic rx_empty,
        input logic ovf,
        input logic unf
    );
        logic [STAT_W-1:0] s;
        s              = '0;
        s[ST_TX_FULL]  = tx_full;
        s[ST_TX_EMPTY] = tx_empty;
        s[ST_RX_FULL]  = rx_full;
        s[ST_RX_EMPTY] = rx_empty;
        s[ST_OVF]      = ovf;
        s[ST_UNF]      = unf;
        return s;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock FIFO used for every TX and RX queue of io_channels.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   i_clr         synchronous clear, overrides push and pop
//   i_push/i_data write request and data
//   i_pop         read request (head advances at clk)
//   o_data        current head entry
//   o_full        FIFO holds DEPTH entries
//   o_empty       FIFO holds no entries
// A push to a full FIFO is accepted when a pop happens in the same cycle;
// a pop of an empty FIFO is ignored while a concurrent push is still stored.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    // Extra pointer bit separates full (MSBs differ) from empty (equal).
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    assign o_data = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update; clear wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clr) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/io_channels.sv
// Multi-channel CPU-to-device I/O bridge.
// A CPU on the shared tri-state main_bus selects a channel, pushes bytes
// into that channel's TX FIFO, pops bytes from its RX FIFO and reads a
// status word. Devices drain TX FIFOs and fill RX FIFOs via valid/ready.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   main_bus            shared CPU bus, driven only during a read strobe
//   sel_loadn           latch channel select from main_bus
//   to_devn             push main_bus into selected TX FIFO
//   from_devn           read/pop selected RX FIFO head
//   status_rdn          read selected status, clears its sticky flags
//   flush               synchronous clear of all FIFOs and sticky flags
//   tx_data/valid/ready per-channel device-side TX interface
//   rx_data/valid/ready per-channel device-side RX interface
module io_channels
    import io_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire  [WIDTH-1:0]          main_bus,
    input  logic                      sel_loadn,
    input  logic                      to_devn,
    input  logic                      from_devn,
    input  logic                      status_rdn,
    input  logic                      flush,
    output logic [CHANNELS*WIDTH-1:0] tx_data,
    output logic [CHANNELS-1:0]       tx_valid,
    input  logic [CHANNELS-1:0]       tx_ready,
    input  logic [CHANNELS*WIDTH-1:0] rx_data,
    input  logic [CHANNELS-1:0]       rx_valid,
    output logic [CHANNELS-1:0]       rx_ready
);

    logic [SEL_W-1:0]    r_sel;
    logic                r_run;
    logic [CHANNELS-1:0] r_ovf;
    logic [CHANNELS-1:0] r_unf;

    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_tx_push;
    logic [CHANNELS-1:0] w_tx_pop;
    logic [CHANNELS-1:0] w_tx_full;
    logic [CHANNELS-1:0] w_tx_empty;
    logic [CHANNELS-1:0] w_rx_push;
    logic [CHANNELS-1:0] w_rx_pop;
    logic [CHANNELS-1:0] w_rx_full;
    logic [CHANNELS-1:0] w_rx_empty;
    logic [CHANNELS-1:0] w_stat_clr;
    logic [WIDTH-1:0]    w_tx_head [CHANNELS];
    logic [WIDTH-1:0]    w_rx_head [CHANNELS];

    logic [WIDTH-1:0]    w_rx_sel;
    logic [WIDTH-1:0]    w_stat_sel;
    logic [WIDTH-1:0]    w_bus_out;
    logic                w_bus_oe;
    logic                w_stat_rd;

    // A status read only counts when from_devn is not also claiming the bus.
    assign w_stat_rd = !status_rdn && from_devn;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Out-of-range selects match no channel, so they act on nothing.
        assign w_hit[g]      = (r_sel == SEL_W'(g));
        assign w_tx_push[g]  = !to_devn && w_hit[g];
        assign w_tx_pop[g]   = !w_tx_empty[g] && tx_ready[g];
        assign w_rx_push[g]  = rx_valid[g] && rx_ready[g];
        assign w_rx_pop[g]   = !from_devn && w_hit[g];
        assign w_stat_clr[g] = w_stat_rd && w_hit[g];

        assign tx_data[g*WIDTH +: WIDTH] = w_tx_head[g];
        assign tx_valid[g]               = !w_tx_empty[g];
        assign rx_ready[g]               = r_run && !w_rx_full[g];

        io_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_tx_fifo (
            .clk     (clk),
            .rst_n   (reset),
            .i_clr   (flush),
            .i_push  (w_tx_push[g]),
            .i_data  (main_bus),
            .i_pop   (w_tx_pop[g]),
            .o_data  (w_tx_head[g]),
            .o_full  (w_tx_full[g]),
            .o_empty (w_tx_empty[g])
        );

        io_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_rx_fifo (
            .clk     (clk),
            .rst_n   (reset),
            .i_clr   (flush),
            .i_push  (w_rx_push[g]),
            .i_data  (rx_data[g*WIDTH +: WIDTH]),
            .i_pop   (w_rx_pop[g]),
            .o_data  (w_rx_head[g]),
            .o_full  (w_rx_full[g]),
            .o_empty (w_rx_empty[g])
        );
    end

    // Channel select register; flush leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel <= '0;
        end else if (!sel_loadn) begin
            r_sel <= SEL_W'(main_bus);
        end
    end

    // Holds rx_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Sticky flags: a status read clears, a new event in the same cycle sets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= '0;
            r_unf <= '0;
        end else if (flush) begin
            r_ovf <= '0;
            r_unf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~w_stat_clr) | (w_tx_push & w_tx_full & ~w_tx_pop);
            r_unf <= (r_unf & ~w_stat_clr) | (w_rx_pop & w_rx_empty);
        end
    end

    // Read mux for the selected channel; zero when nothing is selected.
    always_comb begin
        w_rx_sel   = '0;
        w_stat_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_hit[i]) begin
                w_rx_sel   = w_rx_empty[i] ? '0 : w_rx_head[i];
                w_stat_sel = WIDTH'(pack_status(w_tx_full[i], w_tx_empty[i],
                                                w_rx_full[i], w_rx_empty[i],
                                                r_ovf[i], r_unf[i]));
            end
        end
    end

    assign w_bus_out = !from_devn ? w_rx_sel : w_stat_sel;
    assign w_bus_oe  = reset && (!from_devn || !status_rdn);
    assign main_bus  = w_bus_oe ? w_bus_out : {WIDTH{1'bz}};

endmodule

// File: tb/tb_io_channels.sv
// Directed bench for io_channels: inputs change at negedge, outputs are
// sampled between edges, expected values are hand-computed constants.
module tb_io_channels;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned D  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            sel_loadn;
    logic            to_devn;
    logic            from_devn;
    logic            status_rdn;
    logic            flush;
    logic [CH*W-1:0] tx_data;
    logic [CH-1:0]   tx_valid;
    logic [CH-1:0]   tx_ready;
    logic [CH*W-1:0] rx_data;
    logic [CH-1:0]   rx_valid;
    logic [CH-1:0]   rx_ready;
    wire  [W-1:0]    main_bus;

    logic            cpu_oe;
    logic [W-1:0]    cpu_d;
    logic [W-1:0]    v;

    int checks = 0;
    int errors = 0;

    assign main_bus = cpu_oe ? cpu_d : {W{1'bz}};

    always #5 clk = ~clk;

    io_channels #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .DEPTH    (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .main_bus   (main_bus),
        .sel_loadn  (sel_loadn),
        .to_devn    (to_devn),
        .from_devn  (from_devn),
        .status_rdn (status_rdn),
        .flush      (flush),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sel_load(input logic [W-1:0] s);
        cpu_d = s; cpu_oe = 1'b1; sel_loadn = 1'b0;
        tick();
        sel_loadn = 1'b1; cpu_oe = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        cpu_d = d; cpu_oe = 1'b1; to_devn = 1'b0;
        tick();
        to_devn = 1'b1; cpu_oe = 1'b0;
    endtask

    task automatic rd_rx(output logic [W-1:0] d);
        from_devn = 1'b0;
        #1 d = main_bus;
        tick();
        from_devn = 1'b1;
    endtask

    task automatic rd_status(output logic [W-1:0] d);
        status_rdn = 1'b0;
        #1 d = main_bus;
        tick();
        status_rdn = 1'b1;
    endtask

    task automatic rx_send(input int ch, input logic [W-1:0] d);
        rx_valid[ch] = 1'b1;
        rx_data[ch*W +: W] = d;
        tick();
        rx_valid[ch] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; sel_loadn = 1'b1; to_devn = 1'b1; from_devn = 1'b1;
        status_rdn = 1'b1; flush = 1'b0; tx_ready = '0; rx_data = '0;
        rx_valid = '0; cpu_oe = 1'b0; cpu_d = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_rx_ready", 32'(rx_ready), 32'h0);
        reset = 1'b1;
        #1 chk("rx_ready_before_edge", 32'(rx_ready), 32'h0);
        tick();
        chk("rx_ready_after_edge", 32'(rx_ready), 32'hF);
        rd_status(v);
        chk("reset_status_ch0", 32'(v), 32'h0A);

        // Single TX transfer on channel 2
        sel_load(8'd2);
        tx_ready = 4'b0100;
        push(8'h41);
        chk("tx2_valid", 32'(tx_valid), 32'h4);
        chk("tx2_data", 32'(tx_data[2*W +: W]), 32'h41);
        tick();
        chk("tx2_drained", 32'(tx_valid), 32'h0);
        tx_ready = '0;

        // Overflow on channel 0: fifth push dropped
        sel_load(8'd0);
        for (int i = 1; i <= 5; i++) push(W'(i));
        chk("ovf_tx_valid", 32'(tx_valid), 32'h1);
        rd_status(v);
        chk("ovf_status", 32'(v), 32'h19);
        tx_ready = 4'b0001;
        for (int i = 1; i <= int'(D); i++) begin
            chk("drain_data", 32'(tx_data[W-1:0]), 32'(i));
            tick();
        end
        tx_ready = '0;
        chk("drain_empty", 32'(tx_valid), 32'h0);
        rd_status(v);
        chk("ovf_cleared_status", 32'(v), 32'h0A);

        // Push and pop together on a full FIFO: no overflow
        for (int i = 0; i < int'(D); i++) push(W'(8'h10 + i));
        tx_ready = 4'b0001;
        push(8'h14);
        tx_ready = '0;
        chk("full_pushpop_head", 32'(tx_data[W-1:0]), 32'h11);
        rd_status(v);
        chk("full_pushpop_status", 32'(v), 32'h09);

        // Flush while pushing into the full channel 0
        cpu_d = 8'h77; cpu_oe = 1'b1; to_devn = 1'b0; flush = 1'b1;
        tick();
        to_devn = 1'b1; cpu_oe = 1'b0; flush = 1'b0;
        chk("flush_tx_valid", 32'(tx_valid), 32'h0);
        rd_status(v);
        chk("flush_status", 32'(v), 32'h0A);
        push(8'h33);
        chk("flush_sel0_kept", 32'(tx_valid), 32'h1);
        chk("flush_sel0_data", 32'(tx_data[W-1:0]), 32'h33);

        // Flush keeps a non-reset select and empties RX FIFOs
        sel_load(8'd3);
        rx_send(2, 8'h99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(8'h66);
        chk("flush_sel3_kept", 32'(tx_valid), 32'h8);
        sel_load(8'd2);
        rd_status(v);
        chk("flush_rx_empty", 32'(v), 32'h0A);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // RX path on channel 1 with underflow
        rx_send(1, 8'hA5);
        rx_send(1, 8'h5A);
        sel_load(8'd1);
        rd_rx(v);
        chk("rx1_first", 32'(v), 32'hA5);
        rd_rx(v);
        chk("rx1_second", 32'(v), 32'h5A);
        rd_rx(v);
        chk("rx1_underflow_data", 32'(v), 32'h00);
        rd_status(v);
        chk("rx1_underflow_status", 32'(v), 32'h2A);

        // from_devn wins over status_rdn
        rx_send(1, 8'h3C);
        from_devn = 1'b0; status_rdn = 1'b0;
        #1 v = main_bus;
        tick();
        from_devn = 1'b1; status_rdn = 1'b1;
        chk("priority_rx_data", 32'(v), 32'h3C);
        rd_status(v);
        chk("priority_after_status", 32'(v), 32'h0A);

        // Out-of-range select
        sel_load(8'd7);
        push(8'hFF);
        chk("sel7_tx_valid", 32'(tx_valid), 32'h0);
        rd_status(v);
        chk("sel7_status", 32'(v), 32'h00);
        rd_rx(v);
        chk("sel7_rx", 32'(v), 32'h00);

        // Empty RX FIFO: concurrent device push and CPU pop
        sel_load(8'd0);
        rx_valid[0] = 1'b1; rx_data[W-1:0] = 8'h5C; from_devn = 1'b0;
        #1 v = main_bus;
        tick();
        rx_valid[0] = 1'b0; from_devn = 1'b1;
        chk("rx0_empty_pop_data", 32'(v), 32'h00);
        rd_status(v);
        chk("rx0_empty_pop_status", 32'(v), 32'h22);
        rd_rx(v);
        chk("rx0_push_kept", 32'(v), 32'h5C);

        // Reset mid-burst with three queued TX entries
        push(8'hA1); push(8'hA2); push(8'hA3);
        chk("burst_tx_valid", 32'(tx_valid), 32'h1);
        cpu_d = 8'hA4; cpu_oe = 1'b1; to_devn = 1'b0;
        #2 reset = 1'b0;
        #1 chk("midreset_tx_valid", 32'(tx_valid), 32'h0);
        chk("midreset_rx_ready", 32'(rx_ready), 32'h0);
        @(negedge clk);
        reset = 1'b1; to_devn = 1'b1; cpu_oe = 1'b0;
        tick();
        chk("postreset_tx_valid", 32'(tx_valid), 32'h0);
        rd_status(v);
        chk("postreset_status_ch0", 32'(v), 32'h0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
